pool_dataflow_ctrl: RTL and testbench
=====================================

# pool_dataflow_ctrl

Dataflow start/done sequencer for the pool pipeline (pool_1D → pool_2D → hs2axis). It fans one top-level ap_ctrl_hs handshake out to the three processes. Each process receives exactly one start per accepted top-level transaction, and the block merges per-process ready/done into top-level ap_ready/ap_done/ap_idle. It sits between the pool top control port and the process instances, and replaces the ad-hoc ready-count logic in the generated top. An optional watchdog flags a stalled pipeline and snapshots which processes were busy.

## Interface
Parameters:
- PROC_NUM, 3, number of dataflow processes; index 0 = pool_1D, 1 = pool_2D, 2 = hs2axis.
- CNT_W, 2, width of per-process done counters and the pending-transaction counter.
- WDOG_W, 16, watchdog counter width.
- WDOG_LIMIT, 16'd4096, idle-progress cycles before stall trips.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- ap_start  in  1  top-level start request; held until ap_ready.
- ap_ready  out  1  top-level transaction accepted (combinational, see Timing).
- ap_done  out  1  registered one-cycle pulse per completed transaction.
- ap_idle  out  1  no transaction pending and all processes idle.
- proc_start  out  PROC_NUM  per-process ap_start.
- proc_ready  in  PROC_NUM  per-process ap_ready.
- proc_done  in  PROC_NUM  per-process ap_done (one-cycle pulses).
- proc_idle  in  PROC_NUM  per-process ap_idle.
- iter_count  out  32  completed-transaction count, wraps at 2^32.
- stall  out  1  watchdog trip flag, sticky.
- stall_vec  out  PROC_NUM  ~proc_idle snapshot at trip.

## Operation
- ready_latch[PROC_NUM]: bit i sets on proc_start[i] & proc_ready[i].
- proc_start[i] = ap_start & ~ready_latch[i] & ~ap_rst.
- all_ready = &(ready_latch | (proc_start & proc_ready)).
- ap_ready = ap_start & all_ready. On ap_ready, ready_latch clears to 0. Processes readying early wait with start low.
- Ready-side FSM, two states:
  - S_IDLE: no latch bits set. Goes to S_ISSUE when ap_start is asserted and all_ready is not.
  - S_ISSUE: returns to S_IDLE on ap_ready.
  - An ap_start that is ready in the same cycle stays in S_IDLE.
- done_cnt[i] (CNT_W bits):
  - Increments on proc_done[i].
  - When every done_cnt[i] + proc_done[i] is nonzero, ap_done is registered high next cycle and every counter is decremented by 1 (net of a same-cycle increment).
  - A done arriving while its counter is already at max is an error: counter saturates; covered by a bench assertion.
- pending (CNT_W bits):
  - +1 on ap_ready, −1 on ap_done pulse, unchanged when both occur in the same cycle.
  - ap_idle = (pending == 0) & (&proc_idle).
- iter_count increments on each ap_done pulse.

## Timing
- Reset values: ap_done 0, iter_count 0, stall 0, stall_vec 0, ready_latch 0, done_cnt 0, pending 0, FSM S_IDLE.
- During ap_rst, proc_start is forced 0. ap_ready and ap_idle follow their equations with cleared state.
- ap_ready is combinational, zero latency, in the same cycle the last process readies.
- ap_done follows the final proc_done by exactly 1 cycle.
- Overlapping transactions: a process may ready transaction n+1 before done n. Done counters absorb up to 2^CNT_W−1 outstanding completions per process.
- Simultaneous ready and done of the same process are handled independently in one cycle.
- ap_rst mid-transaction: all state is discarded next edge; no ap_done is emitted for the aborted transaction.

## Configuration
- POOL_DFC_WATCHDOG_EN defined:
  - wdog counter runs while pending != 0, and clears on any proc_ready, proc_done or ap_ready.
  - On reaching WDOG_LIMIT, stall ← 1 and stall_vec ← ~proc_idle. Both are sticky until ap_rst; the counter holds.
- Not defined: no counter; stall and stall_vec are tied 0.

## Structure
- Shared package pool_dfc_pkg:
  - PROC_NUM constant.
  - Process index localparams PROC_POOL_1D = 0, PROC_POOL_2D = 1, PROC_HS2AXIS = 2.
  - Ready-FSM state typedef (S_IDLE, S_ISSUE).
- One sub-module, pool_dfc_watchdog: counter, trip flag and snapshot register. It is instantiated only under POOL_DFC_WATCHDOG_EN.

## Test plan
- Reset then ap_start=1, all proc_ready asserted cycle 2 → proc_start = 3'b111 cycle 1–2, ap_ready high cycle 2, ready_latch 0 cycle 3.
- Staggered readies (proc 0 @ t1, proc 2 @ t3, proc 1 @ t5) → proc_start[0] drops after t1, proc_start[2] after t3; ap_ready only at t5.
- proc_done 0, 1, 2 at t10, t12, t15 → ap_done pulse at t16, iter_count = 1, pending 1→0, ap_idle high once proc_idle = 3'b111.
- Two overlapping transactions: second ap_ready before first done, proc 2 done twice before proc 1 → two ap_done pulses in completion order, no counter saturation, iter_count = 2.
- ap_rst asserted mid-S_ISSUE with ready_latch = 3'b001 → next cycle proc_start = 0, pending 0, no ap_done, iter_count 0.
- With POOL_DFC_WATCHDOG_EN, WDOG_LIMIT = 8, transaction started and proc 1 never done → stall = 1 eight cycles after last event, stall_vec = 3'b010, holds until ap_rst.

Source files
------------

// File: rtl/pool_dfc_pkg.sv
// Shared definitions for the pool dataflow start/done sequencer: process count,
// process indices and the ready-side FSM state type.
package pool_dfc_pkg;

  localparam int PROC_NUM = 3;

  localparam int PROC_POOL_1D = 0;
  localparam int PROC_POOL_2D = 1;
  localparam int PROC_HS2AXIS = 2;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } ready_state_t;

endpackage

// File: rtl/pool_dfc_watchdog.sv
// Stall watchdog for the pool dataflow sequencer: counts quiet cycles while work
// is pending and latches a sticky trip flag plus a snapshot of busy processes.
module pool_dfc_watchdog
  import pool_dfc_pkg::*;
#(
  parameter int                PROC_NUM   = 3,
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'd4096
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                run,
  input  logic                kick,
  input  logic [PROC_NUM-1:0] busy,
  output logic                stall,
  output logic [PROC_NUM-1:0] stall_vec
);

  logic [WDOG_W-1:0] wdog_cnt;

  // Once tripped everything freezes until reset, so the snapshot is the state at the trip.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wdog_cnt  <= '0;
      stall     <= 1'b0;
      stall_vec <= '0;
    end else if (!stall) begin
      if (kick) begin
        wdog_cnt <= '0;
      end else if (run) begin
        if (wdog_cnt == WDOG_LIMIT - 1'b1) begin
          wdog_cnt  <= WDOG_LIMIT;
          stall     <= 1'b1;
          stall_vec <= busy;
        end else begin
          wdog_cnt <= wdog_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pool_dataflow_ctrl.sv
// Fans one ap_ctrl_hs handshake out to the pool_1D/pool_2D/hs2axis processes and
// merges their ready/done/idle. Optional stall watchdog: POOL_DFC_WATCHDOG_EN.
module pool_dataflow_ctrl
  import pool_dfc_pkg::*;
#(
  parameter int                PROC_NUM   = pool_dfc_pkg::PROC_NUM,
  parameter int                CNT_W      = 2,
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'd4096
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_ready,
  output logic                ap_done,
  output logic                ap_idle,
  output logic [PROC_NUM-1:0] proc_start,
  input  logic [PROC_NUM-1:0] proc_ready,
  input  logic [PROC_NUM-1:0] proc_done,
  input  logic [PROC_NUM-1:0] proc_idle,
  output logic [31:0]         iter_count,
  output logic                stall,
  output logic [PROC_NUM-1:0] stall_vec
);

  logic [PROC_NUM-1:0] ready_latch;
  logic [PROC_NUM-1:0] ready_now;
  logic                all_ready;
  ready_state_t        state;

  logic [CNT_W-1:0]    done_cnt [PROC_NUM];
  logic [CNT_W:0]      done_sum [PROC_NUM];
  logic                all_done;
  logic [CNT_W-1:0]    pending;

  // A process that has already readied this transaction sees start low until ap_ready.
  assign proc_start = {PROC_NUM{ap_start & ~ap_rst}} & ~ready_latch;
  assign ready_now  = proc_start & proc_ready;
  assign all_ready  = &(ready_latch | ready_now);
  assign ap_ready   = ap_start & all_ready;
  assign ap_idle    = (pending == '0) & (&proc_idle);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ready_latch <= '0;
      state       <= S_IDLE;
    end else begin
      ready_latch <= ap_ready ? '0 : (ready_latch | ready_now);
      case (state)
        S_IDLE:  if (ap_start && !all_ready) state <= S_ISSUE;
        S_ISSUE: if (ap_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < PROC_NUM; i++) begin
      done_sum[i] = {1'b0, done_cnt[i]} + (CNT_W+1)'(proc_done[i]);
      if (done_sum[i] == '0) all_done = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ap_done <= 1'b0;
      for (int i = 0; i < PROC_NUM; i++) done_cnt[i] <= '0;
    end else begin
      ap_done <= all_done;
      for (int i = 0; i < PROC_NUM; i++) begin
        if (all_done) begin
          done_cnt[i] <= CNT_W'(done_sum[i] - (CNT_W+1)'(1));
        end else if (done_sum[i][CNT_W]) begin
          done_cnt[i] <= '1;
        end else begin
          done_cnt[i] <= done_sum[i][CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      pending    <= '0;
      iter_count <= '0;
    end else begin
      case ({ap_ready, ap_done})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
      if (ap_done) iter_count <= iter_count + 32'd1;
    end
  end

`ifdef POOL_DFC_WATCHDOG_EN
  pool_dfc_watchdog #(
    .PROC_NUM   (PROC_NUM),
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_watchdog (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .run       (pending != '0),
    .kick      ((|proc_ready) | (|proc_done) | ap_ready),
    .busy      (~proc_idle),
    .stall     (stall),
    .stall_vec (stall_vec)
  );
`else
  // Constant 0; the watchdog parameters remain referenced in this build.
  assign stall     = (WDOG_W == 0) && (WDOG_LIMIT == '0);
  assign stall_vec = '0;
`endif

endmodule

// File: tb/tb_pool_dataflow_ctrl.sv
// Directed bench for pool_dataflow_ctrl: per-cycle vector table plus hand-written
// reset-abort and watchdog sequences.
module tb_pool_dataflow_ctrl;

  localparam int NP = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic          ap_idle;
  logic [NP-1:0] proc_start;
  logic [NP-1:0] proc_ready;
  logic [NP-1:0] proc_done;
  logic [NP-1:0] proc_idle;
  logic [31:0]   iter_count;
  logic          stall;
  logic [NP-1:0] stall_vec;

  int n_tests = 0;
  int n_fail  = 0;

  pool_dataflow_ctrl #(
    .PROC_NUM   (NP),
    .CNT_W      (2),
    .WDOG_W     (16),
    .WDOG_LIMIT (16'd8)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .proc_start (proc_start),
    .proc_ready (proc_ready),
    .proc_done  (proc_done),
    .proc_idle  (proc_idle),
    .iter_count (iter_count),
    .stall      (stall),
    .stall_vec  (stall_vec)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic          rst;
    logic          start;
    logic [NP-1:0] rdy;
    logic [NP-1:0] dn;
    logic [NP-1:0] idl;
    logic [NP-1:0] e_ps;
    logic          e_ready;
    logic          e_done;
    logic          e_idle;
    logic [31:0]   e_iter;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic start, input logic [NP-1:0] rdy,
                     input logic [NP-1:0] dn, input logic [NP-1:0] idl,
                     input logic [NP-1:0] e_ps, input logic e_ready, input logic e_done,
                     input logic e_idle, input logic [31:0] e_iter);
    vec_t v;
    v.rst = rst; v.start = start; v.rdy = rdy; v.dn = dn; v.idl = idl;
    v.e_ps = e_ps; v.e_ready = e_ready; v.e_done = e_done; v.e_idle = e_idle;
    v.e_iter = e_iter;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic start, input logic [NP-1:0] rdy,
                       input logic [NP-1:0] dn, input logic [NP-1:0] idl);
    ap_rst = rst; ap_start = start; proc_ready = rdy; proc_done = dn; proc_idle = idl;
  endtask

  // A done landing on a full counter would be lost.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < NP; i++) begin
        if (proc_done[i] && dut.done_cnt[i] == 2'b11) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_cnt_sat[%0d]: got done on counter %0h expected below 3", i,
                   dut.done_cnt[i]);
        end
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, '0, '0, '1);
    tick();
    tick();

    //  rst st  rdy     dn      idl     ps      rdy dn  idl iter
    add(1, 0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 0, 1, 0);
    add(1, 1, 3'b000, 3'b000, 3'b111, 3'b000, 0, 0, 1, 0);
    add(0, 1, 3'b000, 3'b000, 3'b111, 3'b111, 0, 0, 1, 0);
    add(0, 1, 3'b111, 3'b000, 3'b111, 3'b111, 1, 0, 1, 0);
    add(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    add(0, 0, 3'b000, 3'b001, 3'b000, 3'b000, 0, 0, 0, 0);
    add(0, 0, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0);
    add(0, 0, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0, 0, 0);
    add(0, 0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 1, 0, 0);
    add(0, 0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 0, 1, 1);
    // staggered readies, then a second transaction overlapping the first
    add(0, 1, 3'b001, 3'b000, 3'b111, 3'b111, 0, 0, 1, 1);
    add(0, 1, 3'b000, 3'b000, 3'b110, 3'b110, 0, 0, 0, 1);
    add(0, 1, 3'b100, 3'b000, 3'b110, 3'b110, 0, 0, 0, 1);
    add(0, 1, 3'b000, 3'b000, 3'b010, 3'b010, 0, 0, 0, 1);
    add(0, 1, 3'b010, 3'b000, 3'b000, 3'b010, 1, 0, 0, 1);
    add(0, 1, 3'b111, 3'b000, 3'b000, 3'b111, 1, 0, 0, 1);
    add(0, 0, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0, 0, 1);
    add(0, 0, 3'b000, 3'b100, 3'b000, 3'b000, 0, 0, 0, 1);
    add(0, 0, 3'b000, 3'b001, 3'b000, 3'b000, 0, 0, 0, 1);
    add(0, 0, 3'b000, 3'b011, 3'b000, 3'b000, 0, 0, 0, 1);
    add(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0, 1);
    add(0, 0, 3'b000, 3'b010, 3'b000, 3'b000, 0, 0, 0, 2);
    add(0, 0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 1, 0, 2);
    add(0, 0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 0, 1, 3);
    // ap_ready coinciding with an ap_done pulse leaves pending unchanged
    add(0, 1, 3'b111, 3'b000, 3'b111, 3'b111, 1, 0, 1, 3);
    add(0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 3);
    add(0, 1, 3'b111, 3'b000, 3'b000, 3'b111, 1, 1, 0, 3);
    add(0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 4);
    add(0, 0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 1, 0, 4);
    add(0, 0, 3'b000, 3'b000, 3'b111, 3'b000, 0, 0, 1, 5);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].start, vecs[k].rdy, vecs[k].dn, vecs[k].idl);
      #1;
      check($sformatf("v%0d proc_start", k), 32'(proc_start), 32'(vecs[k].e_ps));
      check($sformatf("v%0d ap_ready", k), 32'(ap_ready), 32'(vecs[k].e_ready));
      check($sformatf("v%0d ap_done", k), 32'(ap_done), 32'(vecs[k].e_done));
      check($sformatf("v%0d ap_idle", k), 32'(ap_idle), 32'(vecs[k].e_idle));
      check($sformatf("v%0d iter_count", k), iter_count, vecs[k].e_iter);
      tick();
    end

    // Reset mid-issue with ready_latch = 001 and two of three dones already counted.
    drive(1'b0, 1'b1, 3'b111, 3'b000, 3'b000);
    #1 check("abort ap_ready", 32'(ap_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 3'b000, 3'b011, 3'b000);
    tick();
    drive(1'b0, 1'b1, 3'b001, 3'b000, 3'b000);
    #1 check("abort first ready", 32'(ap_ready), 32'd0);
    tick();
    drive(1'b0, 1'b1, 3'b000, 3'b000, 3'b000);
    #1 check("abort latched start", 32'(proc_start), 32'(3'b110));
    drive(1'b1, 1'b1, 3'b000, 3'b100, 3'b000);
    #1 check("abort start in reset", 32'(proc_start), 32'd0);
    check("abort ready in reset", 32'(ap_ready), 32'd0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 3'b000, 3'b111);
    #1 check("abort ap_done", 32'(ap_done), 32'd0);
    check("abort ap_idle", 32'(ap_idle), 32'd1);
    check("abort iter_count", iter_count, 32'd0);
    drive(1'b0, 1'b0, 3'b000, 3'b100, 3'b111);
    tick();
    drive(1'b0, 1'b1, 3'b000, 3'b000, 3'b111);
    #1 check("abort no stale done", 32'(ap_done), 32'd0);
    check("abort latch cleared", 32'(proc_start), 32'(3'b111));

    // Transaction with process 1 never finishing.
    drive(1'b1, 1'b0, 3'b000, 3'b000, 3'b111);
    tick();
    drive(1'b0, 1'b1, 3'b111, 3'b000, 3'b111);
    tick();
    drive(1'b0, 1'b0, 3'b000, 3'b101, 3'b101);
    tick();
    drive(1'b0, 1'b0, 3'b000, 3'b000, 3'b101);
`ifdef POOL_DFC_WATCHDOG_EN
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("wdog stall c%0d", c), 32'(stall), (c == 8) ? 32'd1 : 32'd0);
    end
    check("wdog stall_vec", 32'(stall_vec), 32'(3'b010));
    drive(1'b0, 1'b0, 3'b010, 3'b000, 3'b111);
    tick();
    drive(1'b0, 1'b0, 3'b000, 3'b000, 3'b111);
    tick();
    check("wdog sticky stall", 32'(stall), 32'd1);
    check("wdog sticky vec", 32'(stall_vec), 32'(3'b010));
    drive(1'b1, 1'b0, 3'b000, 3'b000, 3'b111);
    tick();
    check("wdog reset stall", 32'(stall), 32'd0);
    check("wdog reset vec", 32'(stall_vec), 32'd0);
`else
    for (int c = 1; c <= 12; c++) tick();
    check("no wdog stall", 32'(stall), 32'd0);
    check("no wdog stall_vec", 32'(stall_vec), 32'd0);
    check("stalled pipeline not idle", 32'(ap_idle), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
